// File: rtl/fft_mac_sequencer_pkg.sv
// Shared types and constants for the FFT MAC sequencer.
// Holds the FSM encoding, the FFT size default and the MAC load sub-cycles.
package fft_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned LOG2N_DEFAULT  = 5;
    localparam int unsigned BFLY_PER_STAGE = 16;

    // MAC sub-cycles on which the real and imaginary accumulators are loaded
    localparam logic [2:0] CNT_LD_R = 3'd1;
    localparam logic [2:0] CNT_LD_I = 3'd3;

endpackage

// File: rtl/fft_mac_sequencer_if.sv
// Control/address bundle between the FFT sequencer and the MAC datapath.
// master = sequencer side, slave = datapath / memory side.
interface fft_mac_sequencer_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] count;
    logic       flag;
    logic       sel_B_im;
    logic       sel_W_im;
    logic       sel_A_im;
    logic [2:0] stage;
    logic [4:0] rd_addr_A;
    logic [4:0] rd_addr_B;
    logic [3:0] tw_addr;
    logic       wr_en;
    logic [4:0] wr_addr_A;
    logic [4:0] wr_addr_B;

    modport master (
        input  start,
        output busy, done, count, flag, sel_B_im, sel_W_im, sel_A_im,
        output stage, rd_addr_A, rd_addr_B, tw_addr, wr_en, wr_addr_A, wr_addr_B
    );

    modport slave (
        output start,
        input  busy, done, count, flag, sel_B_im, sel_W_im, sel_A_im,
        input  stage, rd_addr_A, rd_addr_B, tw_addr, wr_en, wr_addr_A, wr_addr_B
    );
endinterface

// File: rtl/fft_mac_sequencer_addr_gen.sv
// Decimation-in-time butterfly address generator (purely combinational).
// Maps (stage, butterfly) to top/bottom data addresses and the twiddle index.
module fft_addr_gen (
    input  logic [2:0] stage,
    input  logic [3:0] b,
    output logic [4:0] rd_addr_A,
    output logic [4:0] rd_addr_B,
    output logic [3:0] tw_addr
);
    logic [4:0] half;
    logic [4:0] pos;
    logic [4:0] grp;

    // Power-of-two arithmetic: mod/div by half become mask/shift
    always_comb begin
        half      = 5'd1 << stage;
        pos       = {1'b0, b} & (half - 5'd1);
        grp       = {1'b0, b} >> stage;
        rd_addr_A = ((grp << stage) << 1) | pos;
        rd_addr_B = rd_addr_A + half;
        tw_addr   = 4'(pos << (3'd4 - stage));
    end
endmodule

// File: rtl/fft_mac_sequencer.sv
// Sequencer for a 4-cycle-per-butterfly complex MAC running a radix-2 DIT FFT.
// Steps count/butterfly/stage, drives operand selects and read/write addresses.
module fft_mac_sequencer
    import fft_mac_sequencer_pkg::*;
#(
    parameter int unsigned LOG2N = LOG2N_DEFAULT
) (
    input logic                 clk_MAC,
    input logic                 rst,
    fft_mac_sequencer_if.master bus
);
    localparam logic [2:0] LAST_STAGE = 3'(LOG2N - 1);
    localparam logic [3:0] LAST_BFLY  = 4'(BFLY_PER_STAGE - 1);

    state_t     state;
    logic [2:0] count;
    logic [2:0] stage;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic       flag;
    logic       wr_en;
    logic [4:0] wr_addr_A;
    logic [4:0] wr_addr_B;
    logic [4:0] gen_addr_A;
    logic [4:0] gen_addr_B;
    logic [3:0] gen_tw;

    fft_addr_gen u_addr_gen (
        .stage     (stage),
        .b         (b),
        .rd_addr_A (gen_addr_A),
        .rd_addr_B (gen_addr_B),
        .tw_addr   (gen_tw)
    );

    always_ff @(posedge clk_MAC) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            stage     <= '0;
            b         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            flag      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr_A <= '0;
            wr_addr_B <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        flag  <= 1'b1;
                        count <= '0;
                        stage <= '0;
                        b     <= '0;
                    end
                end
                ST_RUN: begin
                    if (count == CNT_LD_I) begin
                        // Butterfly complete: capture its addresses for the write-back
                        wr_en     <= 1'b1;
                        wr_addr_A <= gen_addr_A;
                        wr_addr_B <= gen_addr_B;
                        count     <= '0;
                        if (b == LAST_BFLY) begin
                            b <= '0;
                            if (stage == LAST_STAGE) begin
                                state <= ST_DRAIN;
                                flag  <= 1'b0;
                                stage <= '0;
                            end else begin
                                stage <= stage + 3'd1;
                            end
                        end else begin
                            b <= b + 4'd1;
                        end
                    end else begin
                        count <= count + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.flag      = flag;
    assign bus.count     = count;
    assign bus.stage     = stage;
    assign bus.sel_B_im  = count[0];
    assign bus.sel_W_im  = count[0] ^ count[1];
    assign bus.sel_A_im  = count[1];
    // Read addresses are only meaningful while a butterfly is in flight
    assign bus.rd_addr_A = flag ? gen_addr_A : '0;
    assign bus.rd_addr_B = flag ? gen_addr_B : '0;
    assign bus.tw_addr   = flag ? gen_tw : '0;
    assign bus.wr_en     = wr_en;
    assign bus.wr_addr_A = wr_addr_A;
    assign bus.wr_addr_B = wr_addr_B;

endmodule

// File: tb/tb_fft_mac_sequencer.sv
// Self-checking bench for fft_mac_sequencer: address-generator vector table,
// cycle-accurate full-pass model, spurious starts, reset abort and write scoreboard.
module tb_fft_mac_sequencer;
    import fft_mac_sequencer_pkg::*;

    logic clk_MAC = 1'b0;
    logic rst;

    fft_mac_sequencer_if bus ();

    fft_mac_sequencer #(.LOG2N(5)) dut (
        .clk_MAC (clk_MAC),
        .rst     (rst),
        .bus     (bus)
    );

    logic [2:0] ag_stage;
    logic [3:0] ag_b;
    logic [4:0] ag_a;
    logic [4:0] ag_bb;
    logic [3:0] ag_tw;

    fft_addr_gen u_ag (
        .stage     (ag_stage),
        .b         (ag_b),
        .rd_addr_A (ag_a),
        .rd_addr_B (ag_bb),
        .tw_addr   (ag_tw)
    );

    always #5 clk_MAC = ~clk_MAC;

    typedef struct {
        logic [2:0] stage;
        logic [3:0] b;
        logic [4:0] a;
        logic [4:0] bb;
        logic [3:0] tw;
    } ag_vec_t;

    typedef struct {
        logic sb;
        logic sw;
        logic sa;
    } sel_vec_t;

    ag_vec_t     ag_tab [8];
    sel_vec_t    sel_tab[4];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n_wr;
    int unsigned wcount[5][32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Radix-2 DIT addressing from plain arithmetic
    function automatic void bfly_addr(input int unsigned s, input int unsigned bf,
                                      output int unsigned a, output int unsigned bb,
                                      output int unsigned tw);
        int unsigned half;
        int unsigned pos;
        half = 2 ** s;
        pos  = bf % half;
        a    = (bf / half) * 2 * half + pos;
        bb   = a + half;
        tw   = pos * (16 / half);
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_done"},  32'(bus.done), 0);
        chk({tag, "_flag"},  32'(bus.flag), 0);
        chk({tag, "_count"}, 32'(bus.count), 0);
        chk({tag, "_stage"}, 32'(bus.stage), 0);
        chk({tag, "_rd_A"},  32'(bus.rd_addr_A), 0);
        chk({tag, "_rd_B"},  32'(bus.rd_addr_B), 0);
        chk({tag, "_tw"},    32'(bus.tw_addr), 0);
        chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
        chk({tag, "_wr_A"},  32'(bus.wr_addr_A), 0);
        chk({tag, "_wr_B"},  32'(bus.wr_addr_B), 0);
        chk({tag, "_sels"},  32'({bus.sel_B_im, bus.sel_W_im, bus.sel_A_im}), 0);
    endtask

    // t = cycles since the edge that accepted start (t=1 is the first RUN cycle)
    task automatic check_cycle(input int unsigned t);
        int unsigned k, c, bf, s, a, bb, tw, j, wa, wb, wtw, ws;
        logic run, wexp;
        run = (t >= 1 && t <= 320);
        k   = t - 1;
        c   = k % 4;
        bf  = (k / 4) % 16;
        s   = k / 64;
        if (run) bfly_addr(s, bf, a, bb, tw);
        else begin
            a = 0; bb = 0; tw = 0; c = 0; s = 0;
        end
        chk("busy",     32'(bus.busy),      32'(t <= 321));
        chk("done",     32'(bus.done),      32'(t == 322));
        chk("flag",     32'(bus.flag),      32'(run));
        chk("count",    32'(bus.count),     c);
        chk("stage",    32'(bus.stage),     s);
        chk("rd_A",     32'(bus.rd_addr_A), a);
        chk("rd_B",     32'(bus.rd_addr_B), bb);
        chk("tw",       32'(bus.tw_addr),   tw);
        chk("sel_B_im", 32'(bus.sel_B_im),  32'(sel_tab[c].sb));
        chk("sel_W_im", 32'(bus.sel_W_im),  32'(sel_tab[c].sw));
        chk("sel_A_im", 32'(bus.sel_A_im),  32'(sel_tab[c].sa));
        wexp = (t >= 5 && t <= 321 && (t - 5) % 4 == 0);
        chk("wr_en", 32'(bus.wr_en), 32'(wexp));
        if (wexp) begin
            j = (t - 5) / 4;
            bfly_addr(j / 16, j % 16, wa, wb, wtw);
            chk("wr_A", 32'(bus.wr_addr_A), wa);
            chk("wr_B", 32'(bus.wr_addr_B), wb);
        end
        if (bus.wr_en === 1'b1) begin
            if (bus.flag === 1'b1)
                chk("collision", 32'(bus.rd_addr_A == bus.wr_addr_A || bus.rd_addr_A == bus.wr_addr_B ||
                                     bus.rd_addr_B == bus.wr_addr_A || bus.rd_addr_B == bus.wr_addr_B), 0);
            ws = n_wr / 16;
            if (ws < 5) begin
                wcount[ws][bus.wr_addr_A]++;
                wcount[ws][bus.wr_addr_B]++;
            end
            n_wr++;
        end
    endtask

    // spur_t: cycle to re-pulse start (0 = none); late_start: hold start in DRAIN/DONE;
    // rst_at: cycle at which to assert reset and abort (0 = none)
    task automatic do_pass(input int unsigned spur_t, input logic late_start, input int unsigned rst_at);
        int unsigned ones;
        n_wr = 0;
        for (int unsigned s = 0; s < 5; s++)
            for (int unsigned a = 0; a < 32; a++) wcount[s][a] = 0;
        repeat ($urandom_range(1, 4)) @(negedge clk_MAC);
        chk("idle_busy", 32'(bus.busy), 0);
        bus.start = 1'b1;
        for (int unsigned t = 1; t <= 323; t++) begin
            @(negedge clk_MAC);
            check_cycle(t);
            bus.start = (t == spur_t) || (late_start && (t == 321 || t == 322));
            if (rst_at != 0 && t == rst_at) begin
                bus.start = 1'b0;
                rst = 1'b1;
                @(negedge clk_MAC);
                check_reset("abort");
                rst = 1'b0;
                repeat (6) begin
                    @(negedge clk_MAC);
                    chk("post_abort_wr_en", 32'(bus.wr_en), 0);
                    chk("post_abort_busy",  32'(bus.busy), 0);
                    chk("post_abort_flag",  32'(bus.flag), 0);
                end
                return;
            end
        end
        bus.start = 1'b0;
        chk("wr_pulses", n_wr, 80);
        for (int unsigned s = 0; s < 5; s++) begin
            ones = 0;
            for (int unsigned a = 0; a < 32; a++) if (wcount[s][a] == 1) ones++;
            chk($sformatf("write_once_s%0d", s), ones, 32);
        end
    endtask

    initial begin
        int unsigned s, bf, a, bb, tw;

        ag_tab[0] = '{3'd0, 4'd5,  5'd10, 5'd11, 4'd0};
        ag_tab[1] = '{3'd4, 4'd5,  5'd5,  5'd21, 4'd5};
        ag_tab[2] = '{3'd2, 4'd6,  5'd10, 5'd14, 4'd8};
        ag_tab[3] = '{3'd0, 4'd0,  5'd0,  5'd1,  4'd0};
        ag_tab[4] = '{3'd1, 4'd3,  5'd5,  5'd7,  4'd8};
        ag_tab[5] = '{3'd3, 4'd15, 5'd23, 5'd31, 4'd14};
        ag_tab[6] = '{3'd4, 4'd15, 5'd15, 5'd31, 4'd15};
        ag_tab[7] = '{3'd3, 4'd9,  5'd17, 5'd25, 4'd2};

        // Operand schedule: B_re*W_re, B_im*W_im (+A_re), B_re*W_im, B_im*W_re (+A_im)
        sel_tab[0]        = '{1'b0, 1'b0, 1'b0};
        sel_tab[CNT_LD_R] = '{1'b1, 1'b1, 1'b0};
        sel_tab[2]        = '{1'b0, 1'b1, 1'b1};
        sel_tab[CNT_LD_I] = '{1'b1, 1'b0, 1'b1};

        rst       = 1'b1;
        bus.start = 1'b0;
        ag_stage  = '0;
        ag_b      = '0;
        repeat (3) @(negedge clk_MAC);
        bus.start = 1'b1;
        @(negedge clk_MAC);
        check_reset("por");
        bus.start = 1'b0;
        rst       = 1'b0;

        for (int unsigned i = 0; i < 8; i++) begin
            ag_stage = ag_tab[i].stage;
            ag_b     = ag_tab[i].b;
            #1;
            chk($sformatf("ag_tab%0d_A", i),  32'(ag_a),  32'(ag_tab[i].a));
            chk($sformatf("ag_tab%0d_B", i),  32'(ag_bb), 32'(ag_tab[i].bb));
            chk($sformatf("ag_tab%0d_tw", i), 32'(ag_tw), 32'(ag_tab[i].tw));
        end
        for (int unsigned i = 0; i < 24; i++) begin
            s  = $urandom_range(0, 4);
            bf = $urandom_range(0, 15);
            ag_stage = 3'(s);
            ag_b     = 4'(bf);
            #1;
            bfly_addr(s, bf, a, bb, tw);
            chk("ag_rand_A",  32'(ag_a),  a);
            chk("ag_rand_B",  32'(ag_bb), bb);
            chk("ag_rand_tw", 32'(ag_tw), tw);
        end

        do_pass(0, 1'b0, 0);
        do_pass($urandom_range(2, 300), 1'b1, 0);
        do_pass(0, 1'b0, 157 + $urandom_range(0, 2));
        do_pass(0, 1'b0, 160);
        do_pass($urandom_range(2, 320), 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
